// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file and the MIPS core.
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_e;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
endpackage

// File: rtl/regfile_dump_fsm.sv
// Halt-triggered dump sequencer: walks idx 0..NUM_REGS-1 over a valid/ready handshake.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halted_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              last_o,
  output logic              active_o,
  output logic [ADDR_W-1:0] idx_o
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              halted_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      halted_q <= halted_i;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (halted_i && !halted_q) begin
        state_d = DUMP;
        idx_d   = '0;
      end
      // halted falling mid-dump is deliberately ignored so the log is always complete
      DUMP: if (ready_i) begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: if (!halted_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign valid_o  = (state_q == DUMP);
  assign active_o = (state_q == DUMP);
  assign last_o   = valid_o && (idx_q == LAST_IDX);
  assign idx_o    = idx_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and halt dump port.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_num,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_num,
  input  logic                     halted,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_num,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_last,
  output logic                     dump_active
);
  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_WR-1:0]               wr_act;
  logic                            iss_act;

  // Real, writable register: in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int w = 0; w < NUM_WR; w++)
      wr_act[w] = wr_we[w] && !dump_active && addr_ok(wr_num[w*ADDR_W +: ADDR_W]);
    iss_act = iss_valid && !dump_active && addr_ok(iss_num);
  end

  // Ascending port order: highest-indexed port lands last; issue set beats writeback clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_act[w]) begin
        mem_d[wr_num[w*ADDR_W +: ADDR_W]]  = wr_data[w*DATA_W +: DATA_W];
        busy_d[wr_num[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (iss_act) busy_d[iss_num] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbsy;

    assign ra = rd_num[p*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = '0;
      rbsy = 1'b0;
      if (addr_ok(ra)) begin
        rdat = mem_q[ra];
        rbsy = busy_q[ra];
      end
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act[w] && (wr_num[w*ADDR_W +: ADDR_W] == ra)) begin
          rdat = wr_data[w*DATA_W +: DATA_W];
          rbsy = 1'b0;
        end
      end
`endif
    end

    assign rd_data[p*DATA_W +: DATA_W] = rdat;
    assign rd_busy[p]                  = rbsy;
  end

  regfile_dump_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dump (
    .clk_i    (clk),
    .rst_i    (rst),
    .halted_i (halted),
    .ready_i  (dump_ready),
    .valid_o  (dump_valid),
    .last_o   (dump_last),
    .active_o (dump_active),
    .idx_o    (dump_num)
  );

  assign dump_data = mem_q[dump_num];
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations, a negedge monitor checks them.
module tb_regfile_mp;
  localparam int DW = 32, NR = 32, AW = 5, NRD = 2, NWR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NRD*AW-1:0] rd_num = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_we = '0;
  logic [NWR*AW-1:0] wr_num = '0;
  logic [NWR*DW-1:0] wr_data = '0;
  logic              iss_valid = 1'b0;
  logic [AW-1:0]     iss_num = '0;
  logic              halted = 1'b0;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [AW-1:0]     dump_num;
  logic [DW-1:0]     dump_data;
  logic              dump_last;
  logic              dump_active;

  regfile_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_we(wr_we), .wr_num(wr_num), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_num(iss_num), .halted(halted),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_num(dump_num),
    .dump_data(dump_data), .dump_last(dump_last), .dump_active(dump_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          port;
    logic [31:0] data;
    logic        busy;
    logic        dv;
  } rd_exp_t;

  typedef struct {
    logic [4:0]  num;
    logic [31:0] data;
    logic        last;
  } beat_exp_t;

  rd_exp_t   rq[$];
  beat_exp_t bq[$];
  logic      rd_chk = 1'b0;
  int        vec_cnt = 0;
  int        err_cnt = 0;
  int        beats = 0;

  logic        hold = 1'b0;
  logic [4:0]  h_num;
  logic [31:0] h_data;

  always @(negedge clk) begin
    if (rd_chk) begin
      if (rq.size() == 0) begin
        err_cnt++;
        $display("FAIL rd_underflow: read strobe with no expectation queued");
      end else begin
        rd_exp_t e;
        logic [31:0] gd;
        logic gb;
        e  = rq.pop_front();
        gd = rd_data[e.port*DW +: DW];
        gb = rd_busy[e.port];
        vec_cnt++;
        if (gd !== e.data || gb !== e.busy || dump_valid !== e.dv) begin
          err_cnt++;
          $display("FAIL rd_%0d port%0d: got data=%h busy=%b dv=%b, want data=%h busy=%b dv=%b",
                   e.tag, e.port, gd, gb, dump_valid, e.data, e.busy, e.dv);
        end
      end
    end
    if (hold && dump_valid === 1'b1) begin
      vec_cnt++;
      if (dump_num !== h_num || dump_data !== h_data) begin
        err_cnt++;
        $display("FAIL dump_hold: got num=%0d data=%h, want num=%0d data=%h",
                 dump_num, dump_data, h_num, h_data);
      end
    end
    hold   = (dump_valid === 1'b1) && !dump_ready;
    h_num  = dump_num;
    h_data = dump_data;
    if (dump_valid === 1'b1 && dump_ready) begin
      if (bq.size() == 0) begin
        err_cnt++;
        $display("FAIL dump_unexpected: beat num=%0d with no expectation queued", dump_num);
      end else begin
        beat_exp_t b;
        b = bq.pop_front();
        vec_cnt++;
        if (dump_num !== b.num || dump_data !== b.data || dump_last !== b.last || dump_active !== 1'b1) begin
          err_cnt++;
          $display("FAIL dump_beat: got num=%0d data=%h last=%b act=%b, want num=%0d data=%h last=%b act=1",
                   dump_num, dump_data, dump_last, dump_active, b.num, b.data, b.last);
        end
      end
      beats++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_we     = '0;
    iss_valid = 1'b0;
    rd_chk    = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_we[p]            = 1'b1;
    wr_num[p*AW +: AW]  = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_valid = 1'b1;
    iss_num   = a;
  endtask

  task automatic rd(input int tag, input int p, input logic [4:0] a,
                    input logic [31:0] d, input logic b, input logic dv);
    rd_exp_t e;
    rd_num[p*AW +: AW] = a;
    e.tag = tag; e.port = p; e.data = d; e.busy = b; e.dv = dv;
    rq.push_back(e);
    rd_chk = 1'b1;
  endtask

  task automatic push_beats(input int n, input logic zero_data);
    beat_exp_t b;
    for (int i = 0; i < n; i++) begin
      b.num  = 5'(i);
      b.data = zero_data ? 32'h0 : 32'(i * 3);
      b.last = (i == NR - 1);
      bq.push_back(b);
    end
  endtask

  task automatic wait_beats(input int target, input int tag);
    for (int c = 0; c < 300 && beats < target; c++) tick();
    vec_cnt++;
    if (beats < target) begin
      err_cnt++;
      $display("FAIL dump_timeout_%0d: got %0d beats, want %0d", tag, beats, target);
    end
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;

    rd(1, 0, 5'd5, 32'h0, 1'b0, 1'b0); tick();
    wr(0, 5'd5, 32'hDEADBEEF); tick();
    rd(2, 0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0); tick();
    wr(0, 5'd0, 32'h1234); tick();
    rd(3, 0, 5'd0, 32'h0, 1'b0, 1'b0); tick();
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); tick();
    rd(4, 1, 5'd7, 32'h22, 1'b0, 1'b0); tick();

    iss(5'd9); tick();
    rd(5, 0, 5'd9, 32'h0, 1'b1, 1'b0); tick();
    wr(0, 5'd9, 32'h99); iss(5'd9); tick();
    rd(6, 0, 5'd9, 32'h99, 1'b1, 1'b0); tick();
    wr(0, 5'd9, 32'h55); tick();
    rd(7, 1, 5'd9, 32'h55, 1'b0, 1'b0); tick();
    iss(5'd0); tick();
    rd(8, 0, 5'd0, 32'h0, 1'b0, 1'b0); tick();

    iss(5'd3); tick();
    wr(0, 5'd3, 32'hA5);
`ifdef REGFILE_BYPASS_EN
    rd(9, 0, 5'd3, 32'hA5, 1'b0, 1'b0);
`else
    rd(9, 0, 5'd3, 32'h0, 1'b1, 1'b0);
`endif
    tick();
    rd(10, 0, 5'd3, 32'hA5, 1'b0, 1'b0); tick();

    for (int i = 1; i < NR; i += 2) begin
      wr(0, 5'(i), 32'(i * 3));
      if (i + 1 < NR) wr(1, 5'(i + 1), 32'((i + 1) * 3));
      tick();
    end
    rd(11, 1, 5'd31, 32'd93, 1'b0, 1'b0); tick();

    // Full dump with ready toggling; writes/issues during the dump must be dropped.
    push_beats(NR, 1'b0);
    halted = 1'b1; tick();
    halted = 1'b0;
    for (int c = 0; c < 300 && beats < NR; c++) begin
      dump_ready = c[0];
      wr(0, 5'd2, 32'hBAD); iss(5'd4);
      tick();
    end
    vec_cnt++;
    if (beats < NR) begin
      err_cnt++;
      $display("FAIL dump_timeout_1: got %0d beats, want %0d", beats, NR);
    end
    dump_ready = 1'b0;
    tick();
    rd(12, 0, 5'd2, 32'd6, 1'b0, 1'b0); tick();
    rd(13, 1, 5'd4, 32'd12, 1'b0, 1'b0); tick();

    // Reset aborts a dump in progress at beat 10.
    push_beats(10, 1'b0);
    dump_ready = 1'b1;
    halted = 1'b1; tick();
    halted = 1'b0;
    wait_beats(NR + 10, 2);
    dump_ready = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    rd(14, 0, 5'd5, 32'h0, 1'b0, 1'b0); tick();
    dump_ready = 1'b1;
    rd(15, 1, 5'd31, 32'h0, 1'b0, 1'b0); tick();

    push_beats(NR, 1'b1);
    halted = 1'b1; tick();
    halted = 1'b0;
    wait_beats(2 * NR + 10, 3);
    dump_ready = 1'b0;
    tick();
    rd(16, 0, 5'd1, 32'h0, 1'b0, 1'b0); tick();
    tick();

    vec_cnt++;
    if (rq.size() != 0 || bq.size() != 0) begin
      err_cnt++;
      $display("FAIL leftover: got rq=%0d bq=%0d pending, want 0 0", rq.size(), bq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
